// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS instruction encoder with a small output FIFO
package instr_encoder_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        OP_NOP,
        OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV,
        OP_JR, OP_JALR, OP_SYSCALL, OP_BREAK,
        OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU,
        OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_BLTZ, OP_BGEZ, OP_BLTZAL, OP_BGEZAL,
        OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
        OP_MFC0, OP_MTC0, OP_ERET,
        OP_DECODE_ERROR
    } op_t;

endpackage

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  op_t         op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic        out_valid,
    input  logic        out_ready,
    output word_t       out_instr,
    output logic        err,
    output logic [15:0] emit_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    function automatic word_t rtype(input logic [4:0] f_rs, input logic [4:0] f_rt,
                                    input logic [4:0] f_rd, input logic [4:0] f_sh,
                                    input logic [5:0] funct);
        return {6'h00, f_rs, f_rt, f_rd, f_sh, funct};
    endfunction

    function automatic word_t itype(input logic [5:0] opc, input logic [4:0] f_rs,
                                    input logic [4:0] f_rt, input logic [15:0] f_imm);
        return {opc, f_rs, f_rt, f_imm};
    endfunction

    word_t enc_word;
    logic  enc_ok;

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        case (op)
            OP_NOP:     enc_word = '0;
            // shifts by constant take no rs; SLL with rd=0 is legal and may equal NOP
            OP_SLL:     enc_word = rtype(5'd0, rt, rd, shamt, 6'h00);
            OP_SRL:     enc_word = rtype(5'd0, rt, rd, shamt, 6'h02);
            OP_SRA:     enc_word = rtype(5'd0, rt, rd, shamt, 6'h03);
            OP_SLLV:    enc_word = rtype(rs, rt, rd, 5'd0, 6'h04);
            OP_SRLV:    enc_word = rtype(rs, rt, rd, 5'd0, 6'h06);
            OP_SRAV:    enc_word = rtype(rs, rt, rd, 5'd0, 6'h07);
            OP_JR:      enc_word = rtype(rs, 5'd0, 5'd0, 5'd0, 6'h08);
            OP_JALR:    enc_word = rtype(rs, 5'd0, rd, 5'd0, 6'h09);
            OP_SYSCALL: enc_word = rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h0C);
            OP_BREAK:   enc_word = rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h0D);
            OP_MFHI:    enc_word = rtype(5'd0, 5'd0, rd, 5'd0, 6'h10);
            OP_MTHI:    enc_word = rtype(rs, 5'd0, 5'd0, 5'd0, 6'h11);
            OP_MFLO:    enc_word = rtype(5'd0, 5'd0, rd, 5'd0, 6'h12);
            OP_MTLO:    enc_word = rtype(rs, 5'd0, 5'd0, 5'd0, 6'h13);
            OP_MULT:    enc_word = rtype(rs, rt, 5'd0, 5'd0, 6'h18);
            OP_MULTU:   enc_word = rtype(rs, rt, 5'd0, 5'd0, 6'h19);
            OP_DIV:     enc_word = rtype(rs, rt, 5'd0, 5'd0, 6'h1A);
            OP_DIVU:    enc_word = rtype(rs, rt, 5'd0, 5'd0, 6'h1B);
            OP_ADD:     enc_word = rtype(rs, rt, rd, 5'd0, 6'h20);
            OP_ADDU:    enc_word = rtype(rs, rt, rd, 5'd0, 6'h21);
            OP_SUB:     enc_word = rtype(rs, rt, rd, 5'd0, 6'h22);
            OP_SUBU:    enc_word = rtype(rs, rt, rd, 5'd0, 6'h23);
            OP_AND:     enc_word = rtype(rs, rt, rd, 5'd0, 6'h24);
            OP_OR:      enc_word = rtype(rs, rt, rd, 5'd0, 6'h25);
            OP_XOR:     enc_word = rtype(rs, rt, rd, 5'd0, 6'h26);
            OP_NOR:     enc_word = rtype(rs, rt, rd, 5'd0, 6'h27);
            OP_SLT:     enc_word = rtype(rs, rt, rd, 5'd0, 6'h2A);
            OP_SLTU:    enc_word = rtype(rs, rt, rd, 5'd0, 6'h2B);
            // REGIMM branches carry their condition in the rt slot
            OP_BLTZ:    enc_word = itype(6'h01, rs, 5'h00, imm);
            OP_BGEZ:    enc_word = itype(6'h01, rs, 5'h01, imm);
            OP_BLTZAL:  enc_word = itype(6'h01, rs, 5'h10, imm);
            OP_BGEZAL:  enc_word = itype(6'h01, rs, 5'h11, imm);
            OP_J:       enc_word = {6'h02, target};
            OP_JAL:     enc_word = {6'h03, target};
            OP_BEQ:     enc_word = itype(6'h04, rs, rt, imm);
            OP_BNE:     enc_word = itype(6'h05, rs, rt, imm);
            OP_BLEZ:    enc_word = itype(6'h06, rs, 5'd0, imm);
            OP_BGTZ:    enc_word = itype(6'h07, rs, 5'd0, imm);
            OP_ADDI:    enc_word = itype(6'h08, rs, rt, imm);
            OP_ADDIU:   enc_word = itype(6'h09, rs, rt, imm);
            OP_SLTI:    enc_word = itype(6'h0A, rs, rt, imm);
            OP_SLTIU:   enc_word = itype(6'h0B, rs, rt, imm);
            OP_ANDI:    enc_word = itype(6'h0C, rs, rt, imm);
            OP_ORI:     enc_word = itype(6'h0D, rs, rt, imm);
            OP_XORI:    enc_word = itype(6'h0E, rs, rt, imm);
            OP_LUI:     enc_word = itype(6'h0F, 5'd0, rt, imm);
            OP_LB:      enc_word = itype(6'h20, rs, rt, imm);
            OP_LH:      enc_word = itype(6'h21, rs, rt, imm);
            OP_LW:      enc_word = itype(6'h23, rs, rt, imm);
            OP_LBU:     enc_word = itype(6'h24, rs, rt, imm);
            OP_LHU:     enc_word = itype(6'h25, rs, rt, imm);
            OP_SB:      enc_word = itype(6'h28, rs, rt, imm);
            OP_SH:      enc_word = itype(6'h29, rs, rt, imm);
            OP_SW:      enc_word = itype(6'h2B, rs, rt, imm);
            OP_MFC0:    enc_word = 32'h4000_0000 | {11'd0, rt, rd, 11'd0};
            OP_MTC0:    enc_word = 32'h4080_0000 | {11'd0, rt, rd, 11'd0};
            OP_ERET:    enc_word = 32'h4200_0018;
            default:    enc_ok   = 1'b0;
        endcase
    end

    word_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            accept;
    logic            push;
    logic            pop;

    assign in_ready  = (count < FULL);
    assign out_valid = (count != '0);
    // mask the head so a drained or freshly reset FIFO shows zero, not stale storage
    assign out_instr = out_valid ? mem[rd_ptr] : '0;
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_ok;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            err        <= 1'b0;
            emit_count <= '0;
        end else begin
            err <= accept && !enc_ok;
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr     <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
                emit_count <= emit_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - directed-vector bench for instr_encoder
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    op_t         op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        err;
    logic [15:0] emit_count;

    int vectors = 0;
    int miscompares = 0;

    instr_encoder #(.DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .imm(imm), .target(target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .err(err), .emit_count(emit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        op_t         v_op;
        logic [4:0]  v_rs, v_rt, v_rd, v_sh;
        logic [15:0] v_imm;
        logic [25:0] v_tgt;
        logic [31:0] v_exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input op_t o, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [4:0] s,
                         input logic [15:0] i, input logic [25:0] t);
        op = o; rs = a; rt = b; rd = c; shamt = s; imm = i; target = t;
        in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input op_t o, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] c, input logic [4:0] s,
                        input logic [15:0] i, input logic [25:0] t);
        drive(o, a, b, c, s, i, t);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{OP_SLL,    5'd9,  5'd1,  5'd2,  5'd3, 16'h0000, 26'd0, 32'h0001_10C0};
        vecs[1] = '{OP_SLL,    5'd0,  5'd0,  5'd0,  5'd0, 16'h0000, 26'd0, 32'h0000_0000};
        vecs[2] = '{OP_BLTZAL, 5'd4,  5'd7,  5'd0,  5'd0, 16'hFFFF, 26'd0, 32'h0490_FFFF};
        vecs[3] = '{OP_LUI,    5'd7,  5'd8,  5'd0,  5'd0, 16'h1234, 26'd0, 32'h3C08_1234};
        vecs[4] = '{OP_SW,     5'd29, 5'd31, 5'd0,  5'd0, 16'h0010, 26'd0, 32'hAFBF_0010};
        vecs[5] = '{OP_MFC0,   5'd0,  5'd2,  5'd12, 5'd0, 16'h0000, 26'd0, 32'h4002_6000};
        vecs[6] = '{OP_JR,     5'd31, 5'd5,  5'd6,  5'd0, 16'h0000, 26'd0, 32'h03E0_0008};
        vecs[7] = '{OP_MFLO,   5'd7,  5'd0,  5'd3,  5'd0, 16'h0000, 26'd0, 32'h0000_1812};
        vecs[8] = '{OP_NOP,    5'd1,  5'd2,  5'd3,  5'd4, 16'hAAAA, 26'd5, 32'h0000_0000};
        vecs[9] = '{OP_BLEZ,   5'd2,  5'd9,  5'd0,  5'd0, 16'h8000, 26'd0, 32'h1840_8000};

        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = OP_NOP; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; target = '0;
        tick(); tick();
        resetn = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_emit_count", 32'(emit_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // single ADDIU with consumer ready
        out_ready = 1'b1;
        send(OP_ADDIU, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'd0);
        check("addiu_valid", 32'(out_valid), 32'd1);
        check("addiu_word", out_instr, 32'h2422_0005);
        tick();
        check("addiu_emit", 32'(emit_count), 32'd1);
        check("addiu_drained", 32'(out_valid), 32'd0);

        // back-to-back ADDU, JAL
        drive(OP_ADDU, 5'd3, 5'd4, 5'd5, 5'd0, 16'h0000, 26'd0);
        tick();
        drive(OP_JAL, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h010_0000);
        check("b2b_addu", out_instr, 32'h0064_2821);
        tick();
        in_valid = 1'b0;
        check("b2b_jal_valid", 32'(out_valid), 32'd1);
        check("b2b_jal", out_instr, 32'h0C10_0000);
        tick();
        check("b2b_emit", 32'(emit_count), 32'd3);
        out_ready = 1'b0;

        foreach (vecs[k]) begin
            send(vecs[k].v_op, vecs[k].v_rs, vecs[k].v_rt, vecs[k].v_rd,
                 vecs[k].v_sh, vecs[k].v_imm, vecs[k].v_tgt);
            check($sformatf("vec%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("vec%0d_word", k), out_instr, vecs[k].v_exp);
            check($sformatf("vec%0d_err", k), 32'(err), 32'd0);
            pop_one();
        end
        check("vec_emit", 32'(emit_count), 32'd13);

        // fill DEPTH=4 with the consumer stalled, fifth request held
        for (int i = 0; i < 4; i++) begin
            send(OP_ADDIU, 5'd0, 5'd1, 5'd0, 5'd0, 16'(i), 26'd0);
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        drive(OP_ADDIU, 5'd0, 5'd1, 5'd0, 5'd0, 16'd99, 26'd0);
        tick();
        check("full_held_ready", 32'(in_ready), 32'd0);
        check("full_head_stable", out_instr, 32'h2401_0000);
        out_ready = 1'b1;
        tick();
        check("full_pop_ready", 32'(in_ready), 32'd1);
        check("full_w1", out_instr, 32'h2401_0001);
        tick();
        in_valid = 1'b0;
        check("full_w2", out_instr, 32'h2401_0002);
        tick();
        check("full_w3", out_instr, 32'h2401_0003);
        tick();
        check("full_w5", out_instr, 32'h2401_0063);
        tick();
        check("full_empty", 32'(out_valid), 32'd0);
        check("full_emit", 32'(emit_count), 32'd18);
        out_ready = 1'b0;

        // ERET followed by unencodable ops
        send(OP_ERET, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'd0);
        check("eret_word", out_instr, 32'h4200_0018);
        check("eret_err", 32'(err), 32'd0);
        send(OP_DECODE_ERROR, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 26'd1);
        check("decerr_err", 32'(err), 32'd1);
        check("decerr_head", out_instr, 32'h4200_0018);
        tick();
        check("decerr_pulse_end", 32'(err), 32'd0);
        send(op_t'(6'd62), 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'd0);
        check("badop_err", 32'(err), 32'd1);
        pop_one();
        check("decerr_nothing_pushed", 32'(out_valid), 32'd0);
        check("decerr_emit", 32'(emit_count), 32'd19);

        // reset with three words buffered and a request on the input
        for (int i = 0; i < 3; i++) begin
            send(OP_ORI, 5'd1, 5'd2, 5'd0, 5'd0, 16'(i + 7), 26'd0);
        end
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        drive(OP_ADDIU, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0001, 26'd0);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_instr", out_instr, 32'd0);
        check("mid_rst_emit", 32'(emit_count), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        tick();
        check("mid_rst_never_emitted", 32'(emit_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
